// File: rtl/dbus_io_responder.sv
// VexRiscv dBus target for board I/O and a machine timer; read responses come one cycle after accept.
// Never applies backpressure: cmd_ready is held high from the first clock edge after reset.
module dbus_io_responder #(
    parameter logic [31:0] BASE_ADDR = 32'hF000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dBus_cmd_valid,
    output logic        dBus_cmd_ready,
    input  logic        dBus_cmd_payload_wr,
    input  logic [31:0] dBus_cmd_payload_address,
    input  logic [31:0] dBus_cmd_payload_data,
    input  logic [1:0]  dBus_cmd_payload_size,
    output logic        dBus_rsp_ready,
    output logic        dBus_rsp_error,
    output logic [31:0] dBus_rsp_data,
    input  logic [3:0]  sw,
    input  logic [3:0]  btn,
    output logic [3:0]  led,
    output logic [2:0]  rgb0,
    output logic [2:0]  rgb1,
    output logic        timerInterrupt
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [3:0] OFF_LED    = 4'h0;
    localparam logic [3:0] OFF_RGB    = 4'h1;
    localparam logic [3:0] OFF_INPUT  = 4'h2;
    localparam logic [3:0] OFF_MT_LO  = 4'h4;
    localparam logic [3:0] OFF_MT_HI  = 4'h5;
    localparam logic [3:0] OFF_CMP_LO = 4'h6;
    localparam logic [3:0] OFF_CMP_HI = 4'h7;

    logic        cmd_ready_q;
    logic        rsp_vld_q, rsp_vld_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic [3:0]  led_q, led_d;
    logic [2:0]  rgb0_q, rgb0_d;
    logic [2:0]  rgb1_q, rgb1_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [PW-1:0] presc_q, presc_d;
    logic        irq_q;
    logic [7:0]  sync1_q, sync2_q;

    logic        accept;
    logic        hit;
    logic [3:0]  off;
    logic [3:0]  be;
    logic        mapped;
    logic [31:0] rd_word;
    logic [31:0] wr_word;
    logic        wr_en;
    logic        rd_en;
    logic        tick;

    assign accept = dBus_cmd_valid && cmd_ready_q;
    assign hit    = (dBus_cmd_payload_address[31:6] == BASE_ADDR[31:6]);
    assign off    = dBus_cmd_payload_address[5:2];
    assign wr_en  = accept && dBus_cmd_payload_wr && hit;
    assign rd_en  = accept && !dBus_cmd_payload_wr;
    assign tick   = (presc_q == PW'(PRESCALE - 1));

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  lanes);
        logic [31:0] r;
        r = old_w;
        for (int l = 0; l < 4; l++) begin
            if (lanes[l]) begin
                r[l*8 +: 8] = new_w[l*8 +: 8];
            end
        end
        return r;
    endfunction

    always_comb begin
        case (dBus_cmd_payload_size)
            2'd0:    be = 4'b0001 << dBus_cmd_payload_address[1:0];
            2'd1:    be = dBus_cmd_payload_address[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // One mux serves both the read path and the old value for lane merging.
    always_comb begin
        rd_word = 32'd0;
        mapped  = 1'b1;
        case (off)
            OFF_LED:    rd_word = {28'd0, led_q};
            OFF_RGB:    rd_word = {25'd0, rgb1_q, 1'b0, rgb0_q};
            OFF_INPUT:  rd_word = {24'd0, sync2_q};
            OFF_MT_LO:  rd_word = mtime_q[31:0];
            OFF_MT_HI:  rd_word = mtime_q[63:32];
            OFF_CMP_LO: rd_word = mtimecmp_q[31:0];
            OFF_CMP_HI: rd_word = mtimecmp_q[63:32];
            default:    mapped  = 1'b0;
        endcase
        wr_word = lane_merge(rd_word, dBus_cmd_payload_data, be);
    end

    always_comb begin
        led_d      = led_q;
        rgb0_d     = rgb0_q;
        rgb1_d     = rgb1_q;
        mtimecmp_d = mtimecmp_q;
        if (wr_en) begin
            case (off)
                OFF_LED:    led_d = wr_word[3:0];
                OFF_RGB: begin
                    rgb0_d = wr_word[2:0];
                    rgb1_d = wr_word[6:4];
                end
                OFF_CMP_LO: mtimecmp_d[31:0]  = wr_word;
                OFF_CMP_HI: mtimecmp_d[63:32] = wr_word;
                default:    ;
            endcase
        end
    end

    // A software write to either mtime half overrides that cycle's increment entirely.
    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr_en && off == OFF_MT_LO) begin
            mtime_d = {mtime_q[63:32], wr_word};
        end else if (wr_en && off == OFF_MT_HI) begin
            mtime_d = {wr_word, mtime_q[31:0]};
        end
    end

    always_comb begin
        rsp_vld_d = rd_en;
        rsp_err_d = rd_en && !(hit && mapped);
        rsp_dat_d = (rd_en && hit && mapped) ? rd_word : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_ready_q <= 1'b0;
            rsp_vld_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= 32'd0;
            led_q       <= 4'd0;
            rgb0_q      <= 3'd0;
            rgb1_q      <= 3'd0;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            presc_q     <= '0;
            irq_q       <= 1'b0;
            sync1_q     <= 8'd0;
            sync2_q     <= 8'd0;
        end else begin
            cmd_ready_q <= 1'b1;
            rsp_vld_q   <= rsp_vld_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
            led_q       <= led_d;
            rgb0_q      <= rgb0_d;
            rgb1_q      <= rgb1_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            presc_q     <= presc_d;
            irq_q       <= (mtime_d >= mtimecmp_d);
            sync1_q     <= {btn, sw};
            sync2_q     <= sync1_q;
        end
    end

    assign dBus_cmd_ready = cmd_ready_q;
    assign dBus_rsp_ready = rsp_vld_q;
    assign dBus_rsp_error = rsp_err_q;
    assign dBus_rsp_data  = rsp_dat_q;
    assign led            = led_q;
    assign rgb0           = rgb0_q;
    assign rgb1           = rgb1_q;
    assign timerInterrupt = irq_q;

endmodule

// File: tb/tb_dbus_io_responder.sv
// Bench for dbus_io_responder: directed scenarios plus random traffic against a register-map model.
module tb_dbus_io_responder;

    localparam logic [31:0] BASE = 32'hF000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dBus_cmd_valid = 1'b0;
    logic        dBus_cmd_ready;
    logic        dBus_cmd_payload_wr = 1'b0;
    logic [31:0] dBus_cmd_payload_address = 32'd0;
    logic [31:0] dBus_cmd_payload_data = 32'd0;
    logic [1:0]  dBus_cmd_payload_size = 2'd2;
    logic        dBus_rsp_ready;
    logic        dBus_rsp_error;
    logic [31:0] dBus_rsp_data;
    logic [3:0]  sw = 4'd0;
    logic [3:0]  btn = 4'd0;
    logic [3:0]  led;
    logic [2:0]  rgb0;
    logic [2:0]  rgb1;
    logic        timerInterrupt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dbus_io_responder #(.BASE_ADDR(BASE), .PRESCALE(1)) dut (
        .clk(clk),
        .reset(reset),
        .dBus_cmd_valid(dBus_cmd_valid),
        .dBus_cmd_ready(dBus_cmd_ready),
        .dBus_cmd_payload_wr(dBus_cmd_payload_wr),
        .dBus_cmd_payload_address(dBus_cmd_payload_address),
        .dBus_cmd_payload_data(dBus_cmd_payload_data),
        .dBus_cmd_payload_size(dBus_cmd_payload_size),
        .dBus_rsp_ready(dBus_rsp_ready),
        .dBus_rsp_error(dBus_rsp_error),
        .dBus_rsp_data(dBus_rsp_data),
        .sw(sw),
        .btn(btn),
        .led(led),
        .rgb0(rgb0),
        .rgb1(rgb1),
        .timerInterrupt(timerInterrupt)
    );

    // Reference model: architectural register contents plus the expected response.
    logic [3:0]  m_led;
    logic [2:0]  m_rgb0, m_rgb1;
    logic [63:0] m_mtime, m_cmp;
    logic [7:0]  m_in1, m_in2;
    bit          exp_vld, exp_err;
    logic [31:0] exp_dat;

    function automatic void model_reset();
        m_led = 0; m_rgb0 = 0; m_rgb1 = 0;
        m_mtime = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
        m_in1 = 0; m_in2 = 0;
        exp_vld = 0; exp_err = 0; exp_dat = 0;
    endfunction

    function automatic void model_read(input logic [31:0] a, output bit err, output logic [31:0] d);
        err = 0;
        d = 32'd0;
        if ((a & 32'hFFFF_FFC0) != BASE) begin
            err = 1;
        end else begin
            case (int'(a[5:2]))
                0: d = 32'(m_led);
                1: d = 32'(m_rgb0) + 32'(m_rgb1) * 16;
                2: d = 32'(m_in2);
                4: d = m_mtime[31:0];
                5: d = m_mtime[63:32];
                6: d = m_cmp[31:0];
                7: d = m_cmp[63:32];
                default: err = 1;
            endcase
        end
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [1:0] sz, input logic [1:0] a);
        logic [31:0] r;
        bit en;
        r = old_w;
        for (int l = 0; l < 4; l++) begin
            case (sz)
                2'd0:    en = (l == int'(a));
                2'd1:    en = ((l / 2) == int'(a[1]));
                default: en = 1;
            endcase
            if (en) r[l*8 +: 8] = new_w[l*8 +: 8];
        end
        return r;
    endfunction

    // Advance one clock: predict the response, then fold the accepted command into the model.
    task automatic step();
        bit acc, w, rv, re, miss;
        logic [31:0] a, d, rd, cur, nw;
        logic [1:0] sz;
        bit mt_written;
        acc = dBus_cmd_valid && dBus_cmd_ready;
        w = dBus_cmd_payload_wr;
        a = dBus_cmd_payload_address;
        d = dBus_cmd_payload_data;
        sz = dBus_cmd_payload_size;
        rv = 0; re = 0; rd = 0;
        if (acc && !w) begin
            rv = 1;
            model_read(a, re, rd);
        end
        @(posedge clk);
        #1;
        mt_written = 0;
        if (acc && w) begin
            model_read(a, miss, cur);
            nw = merge_lanes(cur, d, sz, a[1:0]);
            if (!miss) begin
                case (int'(a[5:2]))
                    0: m_led = nw[3:0];
                    1: begin m_rgb0 = nw[2:0]; m_rgb1 = nw[6:4]; end
                    4: begin m_mtime[31:0] = nw; mt_written = 1; end
                    5: begin m_mtime[63:32] = nw; mt_written = 1; end
                    6: m_cmp[31:0] = nw;
                    7: m_cmp[63:32] = nw;
                    default: ;
                endcase
            end
        end
        if (!mt_written) m_mtime = m_mtime + 64'd1;
        m_in2 = m_in1;
        m_in1 = {btn, sw};
        exp_vld = rv; exp_err = re; exp_dat = rd;
    endtask

    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        dBus_cmd_payload_wr = w;
        dBus_cmd_payload_address = a;
        dBus_cmd_payload_data = d;
        dBus_cmd_payload_size = sz;
        dBus_cmd_valid = 1'b1;
        step();
        dBus_cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (dBus_cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_low: got %b want 0", dBus_cmd_ready); end
        reset = 1'b0;
        model_reset();
        #1;
        total++; if (dBus_cmd_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge: got %b want 0", dBus_cmd_ready); end
        step();
        total++; if (dBus_cmd_ready !== 1'b1) begin bad++; $display("FAIL ready_after_release: got %b want 1", dBus_cmd_ready); end
        total++; if (dBus_rsp_ready !== 1'b0) begin bad++; $display("FAIL reset_rsp_ready: got %b want 0", dBus_rsp_ready); end
        total++; if ({led, rgb0, rgb1} !== 10'd0) begin bad++; $display("FAIL reset_outputs: got %h want 0", {led, rgb0, rgb1}); end
        total++; if (timerInterrupt !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", timerInterrupt); end
    endtask

    task automatic test_led();
        issue(1, BASE, 32'h0000_000A, 2'd2);
        total++; if (led !== 4'hA) begin bad++; $display("FAIL led_write: got %h want a", led); end
        total++; if (dBus_rsp_ready !== 1'b0) begin bad++; $display("FAIL write_no_rsp: got %b want 0", dBus_rsp_ready); end
        issue(0, BASE, 32'd0, 2'd2);
        total++; if (dBus_rsp_ready !== 1'b1 || dBus_rsp_error !== 1'b0) begin bad++; $display("FAIL led_read_rsp: got rdy=%b err=%b want rdy=1 err=0", dBus_rsp_ready, dBus_rsp_error); end
        total++; if (dBus_rsp_data !== 32'h0000_000A) begin bad++; $display("FAIL led_read_data: got %h want 0000000a", dBus_rsp_data); end
        step();
        total++; if (dBus_rsp_ready !== 1'b0) begin bad++; $display("FAIL rsp_single_pulse: got %b want 0", dBus_rsp_ready); end
    endtask

    task automatic test_rgb();
        issue(1, BASE + 32'h4, 32'h0000_0077, 2'd2);
        total++; if (rgb0 !== 3'd7 || rgb1 !== 3'd7) begin bad++; $display("FAIL rgb_word: got %o/%o want 7/7", rgb0, rgb1); end
        issue(1, BASE + 32'h5, 32'h5555_5555, 2'd0);
        total++; if (rgb0 !== 3'd7 || rgb1 !== 3'd7) begin bad++; $display("FAIL rgb_lane1: got %o/%o want 7/7", rgb0, rgb1); end
        issue(1, BASE + 32'h4, 32'h0000_0052, 2'd0);
        total++; if (rgb0 !== 3'b010 || rgb1 !== 3'b101) begin bad++; $display("FAIL rgb_lane0: got %b/%b want 010/101", rgb0, rgb1); end
        issue(1, BASE + 32'h6, 32'hFFFF_FFFF, 2'd1);
        total++; if (rgb0 !== 3'b010 || rgb1 !== 3'b101) begin bad++; $display("FAIL rgb_upper_half: got %b/%b want 010/101", rgb0, rgb1); end
        issue(0, BASE + 32'h4, 32'd0, 2'd0);
        total++; if (dBus_rsp_data !== 32'h0000_0052) begin bad++; $display("FAIL rgb_read: got %h want 00000052", dBus_rsp_data); end
    endtask

    task automatic test_input();
        sw = 4'h3;
        btn = 4'h8;
        repeat (3) step();
        issue(0, BASE + 32'h8, 32'd0, 2'd2);
        total++; if (dBus_rsp_ready !== 1'b1 || dBus_rsp_data !== 32'h0000_0083) begin bad++; $display("FAIL input_read: got rdy=%b data=%h want rdy=1 data=00000083", dBus_rsp_ready, dBus_rsp_data); end
        issue(1, BASE + 32'h8, 32'hFFFF_FFFF, 2'd2);
        issue(0, BASE + 32'h8, 32'd0, 2'd2);
        total++; if (dBus_rsp_data !== 32'h0000_0083) begin bad++; $display("FAIL input_readonly: got %h want 00000083", dBus_rsp_data); end
    endtask

    task automatic test_back_to_back_errors();
        issue(0, BASE + 32'hC, 32'd0, 2'd2);
        total++; if (dBus_rsp_ready !== 1'b1 || dBus_rsp_error !== 1'b1 || dBus_rsp_data !== 32'd0) begin bad++; $display("FAIL unmapped_read: got rdy=%b err=%b data=%h want 1 1 0", dBus_rsp_ready, dBus_rsp_error, dBus_rsp_data); end
        issue(0, BASE + 32'h40, 32'd0, 2'd2);
        total++; if (dBus_rsp_ready !== 1'b1 || dBus_rsp_error !== 1'b1 || dBus_rsp_data !== 32'd0) begin bad++; $display("FAIL miss_read: got rdy=%b err=%b data=%h want 1 1 0", dBus_rsp_ready, dBus_rsp_error, dBus_rsp_data); end
        issue(1, BASE + 32'h40, 32'h0000_0005, 2'd2);
        total++; if (led !== 4'hA) begin bad++; $display("FAIL miss_write_dropped: got %h want a", led); end
    endtask

    task automatic test_timer();
        issue(1, BASE + 32'h1C, 32'd0, 2'd2);
        issue(1, BASE + 32'h18, 32'd20, 2'd2);
        issue(1, BASE + 32'h10, 32'd0, 2'd2);
        total++; if (timerInterrupt !== 1'b0) begin bad++; $display("FAIL irq_after_mtime_clear: got %b want 0", timerInterrupt); end
        repeat (19) step();
        total++; if (timerInterrupt !== 1'b0) begin bad++; $display("FAIL irq_at_19: got %b want 0", timerInterrupt); end
        step();
        total++; if (timerInterrupt !== 1'b1) begin bad++; $display("FAIL irq_at_20: got %b want 1", timerInterrupt); end
        issue(1, BASE + 32'h18, 32'hFFFF_FFFF, 2'd2);
        total++; if (timerInterrupt !== 1'b0) begin bad++; $display("FAIL irq_fall: got %b want 0", timerInterrupt); end
        issue(1, BASE + 32'h10, 32'hFFFF_FFFF, 2'd2);
        step();
        issue(0, BASE + 32'h14, 32'd0, 2'd2);
        total++; if (dBus_rsp_data !== 32'd1) begin bad++; $display("FAIL mtime_hi_carry: got %h want 00000001", dBus_rsp_data); end
        total++; if (dBus_rsp_data !== exp_dat) begin bad++; $display("FAIL mtime_hi_model: got %h want %h", dBus_rsp_data, exp_dat); end
        total++; if (timerInterrupt !== 1'b1) begin bad++; $display("FAIL irq_after_wrap: got %b want 1", timerInterrupt); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0] sz;
        for (int i = 0; i < 300; i++) begin
            if (($urandom % 16) == 0) begin
                sw = 4'($urandom);
                btn = 4'($urandom);
            end
            sz = 2'($urandom % 3);
            a = BASE + 32'($urandom % 16) * 4 + 32'($urandom % 4);
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
            if (($urandom % 8) == 0) a = a ^ (32'h40 << ($urandom % 26));
            dBus_cmd_payload_wr = 1'($urandom);
            dBus_cmd_payload_address = a;
            dBus_cmd_payload_data = $urandom;
            dBus_cmd_payload_size = sz;
            dBus_cmd_valid = (($urandom % 4) != 0);
            step();
            dBus_cmd_valid = 1'b0;
            total++; if (dBus_rsp_ready !== exp_vld || (exp_vld && dBus_rsp_error !== exp_err)) begin bad++; $display("FAIL rand_rsp[%0d]: got rdy=%b err=%b want rdy=%b err=%b", i, dBus_rsp_ready, dBus_rsp_error, exp_vld, exp_err); end
            if (exp_vld) begin
                total++; if (dBus_rsp_data !== exp_dat) begin bad++; $display("FAIL rand_data[%0d]: got %h want %h", i, dBus_rsp_data, exp_dat); end
            end
            total++; if (led !== m_led || rgb0 !== m_rgb0 || rgb1 !== m_rgb1) begin bad++; $display("FAIL rand_io[%0d]: got %h/%o/%o want %h/%o/%o", i, led, rgb0, rgb1, m_led, m_rgb0, m_rgb1); end
            total++; if (timerInterrupt !== (m_mtime >= m_cmp)) begin bad++; $display("FAIL rand_irq[%0d]: got %b want %b", i, timerInterrupt, (m_mtime >= m_cmp)); end
        end
    endtask

    task automatic test_reset_mid();
        issue(1, BASE, 32'h0000_0009, 2'd2);
        issue(0, BASE, 32'd0, 2'd2);
        total++; if (dBus_rsp_ready !== 1'b1) begin bad++; $display("FAIL mid_rsp_before: got %b want 1", dBus_rsp_ready); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (dBus_rsp_ready !== 1'b0 || dBus_cmd_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_bus: got rdy=%b cmd_rdy=%b want 0 0", dBus_rsp_ready, dBus_cmd_ready); end
        total++; if ({led, rgb0, rgb1, timerInterrupt} !== 11'd0) begin bad++; $display("FAIL mid_reset_state: got %h want 0", {led, rgb0, rgb1, timerInterrupt}); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step();
        issue(0, BASE + 32'h10, 32'd0, 2'd2);
        total++; if (dBus_rsp_data !== exp_dat || exp_dat !== 32'd1) begin bad++; $display("FAIL mid_mtime_restart: got %h want 00000001", dBus_rsp_data); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_led();
        test_rgb();
        test_input();
        test_back_to_back_errors();
        test_timer();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
